// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a 2-entry input FIFO.
// Words stream out back-to-back on dout while the buffer holds data.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [2];
    logic             head;
    logic             tail;
    logic [1:0]       occ;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;

    logic             push;
    logic             pop;
    logic             last;
    logic [WIDTH-1:0] head_word;
    logic [WIDTH-1:0] shifted;

    assign ready_out = !rst && (occ != 2'd2);
    assign push      = valid_in && ready_out;
    assign last      = (state == SHIFT) && (bit_cnt == LAST);
    assign pop       = (occ != 2'd0) && ((state == IDLE) || last);
    assign head_word = mem[head];
    assign busy      = (state == SHIFT) || (occ != 2'd0);

    // Outgoing bit always sits at one end of sreg; it is zero when idle.
    assign dout    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[tail] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= 1'b0;
            tail <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            word_cnt   <= 16'd0;
            dout_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        sreg       <= head_word;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                        dout_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        word_cnt <= word_cnt + 16'd1;
                        bit_cnt  <= '0;
                        // Chain straight into the next word to avoid a gap.
                        if (pop) begin
                            sreg <= head_word;
                        end else begin
                            sreg       <= '0;
                            state      <= IDLE;
                            dout_valid <= 1'b0;
                        end
                    end else begin
                        sreg    <= shifted;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
